// File: rtl/rd_ptr_ctl.sv
// Read-domain pointer and status controller for a dual-clock FIFO.
// Synchronises the Gray write pointer and maintains the read pointers, ready flag, occupancy and underflow.
module rd_ptr_ctl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rget,
    input  logic [ADDR_WIDTH:0]   rwptr_gray,
    output logic                  rrdy,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rcount,
    output logic                  runderflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] count_next;
    logic          rinc;

    // Two-flop synchroniser; rq1 feeds rq2 directly so only rq2 may be used downstream.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rwptr_gray;
            rq2 <= rq1;
        end
    end

    always_comb begin
        rinc       = rget & rrdy;
        rbin_next  = rbin + PW'(rinc);
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_s[i] = ^(rq2 >> i);
        end
    end

    assign count_next = wbin_s - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr_gray  <= '0;
            rrdy       <= 1'b0;
            rcount     <= '0;
            raempty    <= 1'b1;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            rptr_gray  <= rgray_next;
            rrdy       <= (rgray_next != rq2);
            rcount     <= count_next;
            raempty    <= (count_next <= AE_TH);
            runderflow <= runderflow | (rget & ~rrdy);
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rd_ptr_ctl.sv
// Self-checking bench for rd_ptr_ctl: directed scenarios plus random traffic
// compared against a count-based occupancy model with a two-edge write-visibility delay.
module tb_rd_ptr_ctl;

    logic       rclk;
    logic       rrst_n;
    logic       rget;
    logic [4:0] rwptr_gray;
    logic       rrdy;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       raempty;
    logic [4:0] rcount;
    logic       runderflow;

    int checks = 0;
    int errors = 0;

    // Reference model: total entries written/read as plain integers
    int wr_total = 0;
    int rd_total = 0;
    int prev1 = 0;
    int prev2 = 0;
    int m_cnt = 0;
    bit m_rrdy = 0;
    bit m_uf = 0;

    rd_ptr_ctl #(.ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rget(rget), .rwptr_gray(rwptr_gray),
        .rrdy(rrdy), .raddr(raddr), .rptr_gray(rptr_gray), .raempty(raempty),
        .rcount(rcount), .runderflow(runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] to_gray(input int n);
        int b;
        b = n % 32;
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_rrdy"},       32'(rrdy),       32'(m_rrdy));
        checkOutput({tag, "_raddr"},      32'(raddr),      32'(rd_total % 16));
        checkOutput({tag, "_rptr_gray"},  32'(rptr_gray),  32'(to_gray(rd_total)));
        checkOutput({tag, "_rcount"},     32'(rcount),     32'(m_cnt));
        checkOutput({tag, "_raempty"},    32'(raempty),    32'(m_cnt <= 2));
        checkOutput({tag, "_runderflow"}, 32'(runderflow), 32'(m_uf));
    endtask

    // One clock: drive inputs, take the edge, advance the model, then compare.
    task automatic applyStimulus(input bit get, input string tag);
        bit accept;
        rget       = get;
        rwptr_gray = to_gray(wr_total);
        @(posedge rclk);
        accept = get && m_rrdy;
        if (get && !m_rrdy) m_uf = 1;
        if (accept) rd_total++;
        m_cnt  = prev2 - rd_total;
        prev2  = prev1;
        prev1  = wr_total;
        m_rrdy = (m_cnt != 0);
        #1;
        checkModel(tag);
    endtask

    // Mid-cycle reset with no clock edge involved; released again before the next edge.
    task automatic doReset(input string tag);
        #2;
        rget   = 1'b1;
        rrst_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_rrdy"},       32'(rrdy),       32'd0);
        checkOutput({tag, "_rst_raempty"},    32'(raempty),    32'd1);
        checkOutput({tag, "_rst_rcount"},     32'(rcount),     32'd0);
        checkOutput({tag, "_rst_raddr"},      32'(raddr),      32'd0);
        checkOutput({tag, "_rst_rptr_gray"},  32'(rptr_gray),  32'd0);
        checkOutput({tag, "_rst_runderflow"}, 32'(runderflow), 32'd0);
        wr_total = 0; rd_total = 0; prev1 = 0; prev2 = 0;
        m_cnt = 0; m_rrdy = 0; m_uf = 0;
        rwptr_gray = 5'd0;
        rget = 1'b0;
        #1;
        rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n     = 1'b1;
        rget       = 1'b0;
        rwptr_gray = 5'(($urandom));

        // Reset from power-up with arbitrary inputs
        doReset("t1");
        applyStimulus(0, "t1_idle");

        // Single entry
        wr_total = 1;
        applyStimulus(0, "t2_w1");
        applyStimulus(0, "t2_w2");
        applyStimulus(0, "t2_w3");
        checkOutput("t2_rrdy_set",   32'(rrdy),    32'd1);
        checkOutput("t2_rcount_one", 32'(rcount),  32'd1);
        applyStimulus(1, "t2_pop");
        checkOutput("t2_raddr_one",  32'(raddr),     32'd1);
        checkOutput("t2_gray_one",   32'(rptr_gray), 32'b00001);
        checkOutput("t2_rrdy_clr",   32'(rrdy),      32'd0);

        // Full FIFO then drain across the wrap
        doReset("t3");
        wr_total = 16;
        for (int i = 0; i < 3; i++) applyStimulus(0, "t3_fill");
        checkOutput("t3_rcount_full", 32'(rcount),  32'd16);
        checkOutput("t3_aempty_full", 32'(raempty), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t3_raddr_seq", 32'(raddr), 32'(i));
            applyStimulus(1, "t3_drain");
        end
        checkOutput("t3_raddr_wrap", 32'(raddr),     32'd0);
        checkOutput("t3_gray_final", 32'(rptr_gray), 32'b11000);
        checkOutput("t3_rcount_end", 32'(rcount),    32'd0);
        checkOutput("t3_rrdy_end",   32'(rrdy),      32'd0);

        // Underflow: pops while empty are ignored and latch the sticky flag
        applyStimulus(1, "t4_uf1");
        checkOutput("t4_uf_first", 32'(runderflow), 32'd1);
        applyStimulus(1, "t4_uf2");
        applyStimulus(1, "t4_uf3");
        checkOutput("t4_gray_held", 32'(rptr_gray), 32'b11000);
        wr_total++;
        for (int i = 0; i < 3; i++) applyStimulus(0, "t4_fill");
        applyStimulus(1, "t4_pop");
        checkOutput("t4_uf_sticky", 32'(runderflow), 32'd1);

        // Pop coinciding with a newly visible write keeps occupancy at one
        wr_total++;
        for (int i = 0; i < 3; i++) applyStimulus(0, "t5_setup");
        checkOutput("t5_cnt_one", 32'(rcount), 32'd1);
        wr_total++;
        applyStimulus(0, "t5_a");
        applyStimulus(0, "t5_b");
        applyStimulus(1, "t5_pop");
        checkOutput("t5_cnt_held",  32'(rcount), 32'd1);
        checkOutput("t5_rrdy_held", 32'(rrdy),   32'd1);

        // Random concurrent traffic; writes never exceed true capacity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1 && (wr_total - rd_total) < 16) wr_total++;
            applyStimulus(bit'($urandom_range(1, 0)), "t5_rand");
        end

        // Reset in the middle of a burst at occupancy 7
        doReset("t6a");
        wr_total = 10;
        for (int i = 0; i < 3; i++) applyStimulus(0, "t6_fill");
        for (int i = 0; i < 3; i++) applyStimulus(1, "t6_burst");
        checkOutput("t6_cnt_seven", 32'(rcount), 32'd7);
        rget = 1'b1;
        doReset("t6b");
        for (int i = 0; i < 4; i++) applyStimulus(1, "t6_empty");
        wr_total = 2;
        for (int i = 0; i < 3; i++) applyStimulus(0, "t6_refill");
        checkOutput("t6_cnt_two", 32'(rcount), 32'd2);
        applyStimulus(1, "t6_pop1");
        applyStimulus(1, "t6_pop2");
        applyStimulus(0, "t6_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
